// File: rtl/alu_arb_pkg.sv
// Shared types and widths for the round-robin ALU arbiter slice.
package alu_arb_pkg;

  localparam int ALU_W  = 8;
  localparam int MODE_W = 4;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_t;

  // Opcode map of the shared alu; the arbiter itself never decodes these.
  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NOTA = 4'd5,
    OP_SHL  = 4'd6,
    OP_SHR  = 4'd7,
    OP_INC  = 4'd8,
    OP_DEC  = 4'd9,
    OP_NAND = 4'd10,
    OP_NOR  = 4'd11,
    OP_XNOR = 4'd12,
    OP_ROL  = 4'd13,
    OP_ROR  = 4'd14,
    OP_PASB = 4'd15
  } alu_op_t;

endpackage

// File: rtl/alu.sv
// Combinational 8-bit ALU shared by all requesters; cout is carry, borrow or
// the bit shifted out, depending on the opcode.
module alu
  import alu_arb_pkg::*;
(
  input  logic [ALU_W-1:0]  in_a,
  input  logic [ALU_W-1:0]  in_b,
  input  logic [MODE_W-1:0] in_mode,
  output logic [ALU_W-1:0]  out_alu,
  output logic              cout
);

  logic [ALU_W:0] wide;

  always_comb begin
    out_alu = '0;
    cout    = 1'b0;
    wide    = '0;
    case (alu_op_t'(in_mode))
      OP_ADD: begin
        wide    = {1'b0, in_a} + {1'b0, in_b};
        out_alu = wide[ALU_W-1:0];
        cout    = wide[ALU_W];
      end
      // Bit 8 of the 9-bit difference is the borrow.
      OP_SUB: begin
        wide    = {1'b0, in_a} - {1'b0, in_b};
        out_alu = wide[ALU_W-1:0];
        cout    = wide[ALU_W];
      end
      OP_AND:  out_alu = in_a & in_b;
      OP_OR:   out_alu = in_a | in_b;
      OP_XOR:  out_alu = in_a ^ in_b;
      OP_NOTA: out_alu = ~in_a;
      OP_SHL: begin
        out_alu = {in_a[ALU_W-2:0], 1'b0};
        cout    = in_a[ALU_W-1];
      end
      OP_SHR: begin
        out_alu = {1'b0, in_a[ALU_W-1:1]};
        cout    = in_a[0];
      end
      OP_INC: begin
        wide    = {1'b0, in_a} + (ALU_W+1)'(1);
        out_alu = wide[ALU_W-1:0];
        cout    = wide[ALU_W];
      end
      OP_DEC: begin
        wide    = {1'b0, in_a} - (ALU_W+1)'(1);
        out_alu = wide[ALU_W-1:0];
        cout    = wide[ALU_W];
      end
      OP_NAND: out_alu = ~(in_a & in_b);
      OP_NOR:  out_alu = ~(in_a | in_b);
      OP_XNOR: out_alu = ~(in_a ^ in_b);
      OP_ROL: begin
        out_alu = {in_a[ALU_W-2:0], in_a[ALU_W-1]};
        cout    = in_a[ALU_W-1];
      end
      OP_ROR: begin
        out_alu = {in_a[0], in_a[ALU_W-1:1]};
        cout    = in_a[0];
      end
      OP_PASB: out_alu = in_b;
      default: out_alu = '0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set req bit at or after ptr,
// wrapping modulo N; returns one-hot grant and its index.
module rr_arbiter #(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_grant
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    sum       = '0;
    idx       = '0;
    // One extra bit holds ptr+k before the modulo fold.
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(N)) begin
        sum = sum - (IDX_W+1)'(N);
      end
      idx = sum[IDX_W-1:0];
      if (!any_grant && req[idx]) begin
        any_grant  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin sharing of one alu between NUM_REQ valid/ready requesters,
// with registered operands and a single id-tagged response channel.
module alu_rr_arbiter
  import alu_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ALU_W-1:0]  req_a,
  input  logic [NUM_REQ*ALU_W-1:0]  req_b,
  input  logic [NUM_REQ*MODE_W-1:0] req_mode,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [ALU_W-1:0]          rsp_data,
  output logic                      rsp_cout,
  output logic                      busy
);

  arb_state_t state, state_next;

  logic [ID_W-1:0]    rr_ptr, ptr_next, grant_idx, op_id;
  logic [NUM_REQ-1:0] grant;
  logic               any_grant;
  logic [ALU_W-1:0]   op_a, op_b, alu_out;
  logic [MODE_W-1:0]  op_mode;
  logic               alu_cout;

  logic [ALU_W-1:0]   a_slice [NUM_REQ];
  logic [ALU_W-1:0]   b_slice [NUM_REQ];
  logic [MODE_W-1:0]  m_slice [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign a_slice[i] = req_a[i*ALU_W +: ALU_W];
    assign b_slice[i] = req_b[i*ALU_W +: ALU_W];
    assign m_slice[i] = req_mode[i*MODE_W +: MODE_W];
  end

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  alu u_alu (
    .in_a    (op_a),
    .in_b    (op_b),
    .in_mode (op_mode),
    .out_alu (alu_out),
    .cout    (alu_cout)
  );

  assign ptr_next = (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + ID_W'(1);
  assign busy     = (state != IDLE);

  // Grant is offered only from IDLE and never while reset is asserted.
  always_comb begin
    state_next = state;
    req_ready  = '0;
    case (state)
      IDLE: begin
        if (any_grant) begin
          req_ready  = rst_n ? grant : '0;
          state_next = EXEC;
        end
      end
      EXEC: state_next = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_mode   <= '0;
      op_id     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_cout  <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (any_grant) begin
            op_a    <= a_slice[grant_idx];
            op_b    <= b_slice[grant_idx];
            op_mode <= m_slice[grant_idx];
            op_id   <= grant_idx;
            rr_ptr  <= ptr_next;
          end
        end
        EXEC: begin
          rsp_data  <= alu_out;
          rsp_cout  <= alu_cout;
          rsp_id    <= op_id;
          rsp_valid <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
          end
        end
        default: rsp_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed and table-driven self-checking bench for alu_rr_arbiter.
module tb_alu_rr_arbiter;

  localparam int N = 4;

  typedef struct {
    logic [1:0] id;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] mode;
    logic [7:0] exp_data;
    logic       exp_cout;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*8-1:0] req_a;
  logic [N*8-1:0] req_b;
  logic [N*4-1:0] req_mode;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [7:0]     rsp_data;
  logic           rsp_cout;
  logic           busy;

  logic [7:0] a_arr [N];
  logic [7:0] b_arr [N];
  logic [3:0] m_arr [N];

  int checks = 0;
  int errors = 0;

  vec_t vecs [24];

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_a[g*8 +: 8]    = a_arr[g];
    assign req_b[g*8 +: 8]    = b_arr[g];
    assign req_mode[g*4 +: 4] = m_arr[g];
  end

  always #5 clk = ~clk;

  alu_rr_arbiter #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_mode  (req_mode),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_cout  (rsp_cout),
    .busy      (busy)
  );

  // Arithmetic reference written with integers: returns {cout, result}.
  function automatic logic [8:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] mode);
    int ia = int'(a);
    int ib = int'(b);
    int r = 0;
    int c = 0;
    case (mode)
      4'd0:  begin r = ia + ib; c = (r > 255) ? 1 : 0; end
      4'd1:  begin r = (ia - ib + 256) % 256; c = (ia < ib) ? 1 : 0; end
      4'd2:  r = ia & ib;
      4'd3:  r = ia | ib;
      4'd4:  r = ia ^ ib;
      4'd5:  r = 255 - ia;
      4'd6:  begin r = ia * 2; c = ia / 128; end
      4'd7:  begin r = ia / 2; c = ia % 2; end
      4'd8:  begin r = ia + 1; c = (ia == 255) ? 1 : 0; end
      4'd9:  begin r = (ia + 255) % 256; c = (ia == 0) ? 1 : 0; end
      4'd10: r = 255 - (ia & ib);
      4'd11: r = 255 - (ia | ib);
      4'd12: r = 255 - (ia ^ ib);
      4'd13: begin r = (ia * 2) % 256 + ia / 128; c = ia / 128; end
      4'd14: begin r = ia / 2 + (ia % 2) * 128; c = ia % 2; end
      default: r = ib;
    endcase
    return {c[0], 8'(r % 256)};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] id, input logic [7:0] a,
                               input logic [7:0] b, input logic [3:0] m, input logic v);
    a_arr[id] = a;
    b_arr[id] = b;
    m_arr[id] = m;
    if (v) req_valid = req_valid | (4'b0001 << id);
    else   req_valid = req_valid & ~(4'b0001 << id);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called in IDLE; expects grant to exp_id and then a full response cycle.
  task automatic grantAndRespond(input logic [1:0] exp_id, input logic drop,
                                 input logic [7:0] exp_data, input logic exp_cout,
                                 input string name);
    int waited = 0;
    #1;
    while (req_ready == '0 && waited < 10) begin
      @(negedge clk);
      #1;
      waited++;
    end
    checkOutput({name, " grant"}, 32'(req_ready), 32'(4'b0001 << exp_id));
    rsp_ready = 1'b1;
    @(negedge clk);
    if (drop) req_valid = req_valid & ~(4'b0001 << exp_id);
    #1;
    checkOutput({name, " exec busy"}, 32'(busy), 32'd1);
    checkOutput({name, " exec rsp_valid"}, 32'(rsp_valid), 32'd0);
    checkOutput({name, " exec ready"}, 32'(req_ready), 32'd0);
    @(negedge clk);
    #1;
    checkOutput({name, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    checkOutput({name, " rsp_id"}, 32'(rsp_id), 32'(exp_id));
    checkOutput({name, " rsp_data"}, 32'(rsp_data), 32'(exp_data));
    checkOutput({name, " rsp_cout"}, 32'(rsp_cout), 32'(exp_cout));
    @(negedge clk);
    #1;
    checkOutput({name, " idle rsp_valid"}, 32'(rsp_valid), 32'd0);
    checkOutput({name, " idle busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [8:0] r;
    logic [7:0] ra;
    logic [7:0] rb;

    // Hand-computed vectors: A5/5A through every mode, plus carry boundaries.
    vecs[0]  = '{2'd0, 8'hA5, 8'h5A, 4'd0,  8'hFF, 1'b0};
    vecs[1]  = '{2'd0, 8'hA5, 8'h5A, 4'd1,  8'h4B, 1'b0};
    vecs[2]  = '{2'd0, 8'hA5, 8'h5A, 4'd2,  8'h00, 1'b0};
    vecs[3]  = '{2'd0, 8'hA5, 8'h5A, 4'd3,  8'hFF, 1'b0};
    vecs[4]  = '{2'd0, 8'hA5, 8'h5A, 4'd4,  8'hFF, 1'b0};
    vecs[5]  = '{2'd0, 8'hA5, 8'h5A, 4'd5,  8'h5A, 1'b0};
    vecs[6]  = '{2'd0, 8'hA5, 8'h5A, 4'd6,  8'h4A, 1'b1};
    vecs[7]  = '{2'd0, 8'hA5, 8'h5A, 4'd7,  8'h52, 1'b1};
    vecs[8]  = '{2'd0, 8'hA5, 8'h5A, 4'd8,  8'hA6, 1'b0};
    vecs[9]  = '{2'd0, 8'hA5, 8'h5A, 4'd9,  8'hA4, 1'b0};
    vecs[10] = '{2'd0, 8'hA5, 8'h5A, 4'd10, 8'hFF, 1'b0};
    vecs[11] = '{2'd0, 8'hA5, 8'h5A, 4'd11, 8'h00, 1'b0};
    vecs[12] = '{2'd0, 8'hA5, 8'h5A, 4'd12, 8'h00, 1'b0};
    vecs[13] = '{2'd0, 8'hA5, 8'h5A, 4'd13, 8'h4B, 1'b1};
    vecs[14] = '{2'd0, 8'hA5, 8'h5A, 4'd14, 8'hD2, 1'b1};
    vecs[15] = '{2'd0, 8'hA5, 8'h5A, 4'd15, 8'h5A, 1'b0};
    vecs[16] = '{2'd1, 8'h00, 8'h01, 4'd1,  8'hFF, 1'b1};
    vecs[17] = '{2'd3, 8'h00, 8'h00, 4'd9,  8'hFF, 1'b1};
    vecs[18] = '{2'd2, 8'hFF, 8'h00, 4'd8,  8'h00, 1'b1};
    vecs[19] = '{2'd1, 8'hFF, 8'h01, 4'd0,  8'h00, 1'b1};
    vecs[20] = '{2'd3, 8'h80, 8'h00, 4'd6,  8'h00, 1'b1};
    vecs[21] = '{2'd2, 8'h01, 8'h00, 4'd7,  8'h00, 1'b1};
    vecs[22] = '{2'd0, 8'h7F, 8'h80, 4'd1,  8'hFF, 1'b1};
    vecs[23] = '{2'd3, 8'h3C, 8'hC3, 4'd15, 8'hC3, 1'b0};

    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    req_valid = '1;
    for (int i = 0; i < N; i++) begin
      a_arr[i] = 8'h00;
      b_arr[i] = 8'h00;
      m_arr[i] = 4'h0;
    end

    // Reset with every requester valid: nothing may be offered.
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("reset req_ready", 32'(req_ready), 32'd0);
    checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("reset rsp_data", 32'(rsp_data), 32'd0);
    checkOutput("reset rsp_cout", 32'(rsp_cout), 32'd0);
    req_valid = '0;
    rst_n     = 1'b1;
    @(negedge clk);

    $display("[TB] single request");
    applyStimulus(2'd2, 8'hF0, 8'h20, 4'd0, 1'b1);
    grantAndRespond(2'd2, 1'b1, 8'h10, 1'b1, "single");

    $display("[TB] vector table");
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].mode, 1'b1);
      grantAndRespond(vecs[i].id, 1'b1, vecs[i].exp_data, vecs[i].exp_cout,
                      $sformatf("vec%0d", i));
    end

    $display("[TB] random operands");
    for (int k = 0; k < 32; k++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      r  = ref_alu(ra, rb, 4'(k % 16));
      applyStimulus(2'd0, ra, rb, 4'(k % 16), 1'b1);
      grantAndRespond(2'd0, 1'b1, r[7:0], r[8], $sformatf("rand%0d", k));
    end

    $display("[TB] round robin");
    doReset();
    for (int i = 0; i < N; i++) begin
      applyStimulus(2'(i), 8'(i), 8'h01, 4'(i), 1'b1);
    end
    for (int k = 0; k < 5; k++) begin
      r = ref_alu(8'(k % 4), 8'h01, 4'(k % 4));
      grantAndRespond(2'(k % 4), 1'b0, r[7:0], r[8], $sformatf("rr%0d", k));
    end
    req_valid = '0;
    @(negedge clk);

    $display("[TB] backpressure");
    doReset();
    applyStimulus(2'd0, 8'h33, 8'h11, 4'd1, 1'b1);
    #1;
    checkOutput("bp grant0", 32'(req_ready), 32'h1);
    rsp_ready = 1'b0;
    @(negedge clk);
    applyStimulus(2'd0, 8'h33, 8'h11, 4'd1, 1'b0);
    applyStimulus(2'd1, 8'h80, 8'h80, 4'd0, 1'b1);
    #1;
    checkOutput("bp exec ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    #1;
    checkOutput("bp rsp_valid", 32'(rsp_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("bp hold valid %0d", k), 32'(rsp_valid), 32'd1);
      checkOutput($sformatf("bp hold id %0d", k), 32'(rsp_id), 32'd0);
      checkOutput($sformatf("bp hold data %0d", k), 32'(rsp_data), 32'h22);
      checkOutput($sformatf("bp hold cout %0d", k), 32'(rsp_cout), 32'd0);
      checkOutput($sformatf("bp hold ready %0d", k), 32'(req_ready), 32'd0);
      @(negedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("bp idle rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("bp idle grant1", 32'(req_ready), 32'h2);
    grantAndRespond(2'd1, 1'b1, 8'h00, 1'b1, "bp next");

    $display("[TB] reset mid-operation");
    doReset();
    applyStimulus(2'd1, 8'h10, 8'h01, 4'd0, 1'b1);
    grantAndRespond(2'd1, 1'b1, 8'h11, 1'b0, "mid pre");
    for (int i = 0; i < N; i++) begin
      applyStimulus(2'(i), 8'(8'h40 + i), 8'h04, 4'd0, 1'b1);
    end
    #1;
    checkOutput("mid grant2", 32'(req_ready), 32'h4);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("mid rst rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("mid rst busy", 32'(busy), 32'd0);
    checkOutput("mid rst ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    grantAndRespond(2'd0, 1'b0, 8'h44, 1'b0, "mid post");
    req_valid = '0;
    @(negedge clk);

    $display("[TB] withdrawn request");
    doReset();
    applyStimulus(2'd0, 8'h01, 8'h02, 4'd0, 1'b1);
    #1;
    checkOutput("wd grant0", 32'(req_ready), 32'h1);
    rsp_ready = 1'b0;
    @(negedge clk);
    applyStimulus(2'd0, 8'h01, 8'h02, 4'd0, 1'b0);
    @(negedge clk);
    applyStimulus(2'd3, 8'h77, 8'h01, 4'd0, 1'b1);
    #1;
    checkOutput("wd resp ready", 32'(req_ready), 32'd0);
    checkOutput("wd rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("wd rsp_data", 32'(rsp_data), 32'h03);
    @(negedge clk);
    applyStimulus(2'd3, 8'h77, 8'h01, 4'd0, 1'b0);
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      checkOutput($sformatf("wd idle ready %0d", k), 32'(req_ready), 32'd0);
      checkOutput($sformatf("wd idle rsp_valid %0d", k), 32'(rsp_valid), 32'd0);
      checkOutput($sformatf("wd idle busy %0d", k), 32'(busy), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
